// File: rtl/pipe_trace_monitor_pkg.sv
// Shared types and helpers for the pipeline trace monitor: control states,
// write-back address width and trace record width.
package pipe_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned WB_ADDR_W = 5;

    // Record layout is {timestamp, wb_addr, wb_data}, timestamp in the MSBs.
    function automatic int unsigned rec_width(input int unsigned cc_w, input int unsigned data_w);
        return cc_w + WB_ADDR_W + data_w;
    endfunction

endpackage

// File: rtl/pipe_trace_monitor_fifo.sv
// First-word-fall-through trace FIFO; head is visible whenever the FIFO is non-empty,
// and a push into a full FIFO is accepted only when a pop happens in the same cycle.
module pipe_trace_monitor_fifo #(
    parameter int unsigned DATA_W = 69,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              rd_en_s, wr_en_s;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign rd_en_s = pop_i && valid_o && !clr_i;
    assign wr_en_s = push_i && (!full_o || rd_en_s) && !clr_i;

    // Pointer and level next-state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (rd_en_s) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            else         rd_ptr_d = rd_ptr_q;
            if (wr_en_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else         wr_ptr_d = wr_ptr_q;
            case ({wr_en_s, rd_en_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only observable through the level-gated head.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) mem_q[wr_ptr_q] <= data_i;
    end

    // Head is forced to zero when empty so reset and clear show all-zero outputs.
    always_comb begin
        if (valid_o) data_o = mem_q[rd_ptr_q];
        else         data_o = '0;
    end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: run/drain/done control around the halt fetch, saturating
// event counters and a write-back trace FIFO read by a host over valid/ready.
module pipe_trace_monitor
    import pipe_trace_monitor_pkg::*;
#(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       PC_W         = 32,
    parameter int unsigned       NUM_STAGES   = 5,
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       CC_W         = 32,
    parameter logic [DATA_W-1:0] HALT_INST    = {DATA_W{1'b1}},
    parameter bit                STOP_ON_HALT = 1'b1,
    localparam int unsigned      REC_W        = rec_width(CC_W, DATA_W),
    localparam int unsigned      LVL_W        = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DATA_W-1:0]    inst_f_i,
    input  logic [PC_W-1:0]      pc_f_i,
    input  logic                 fetch_valid_i,
    input  logic                 stall_f_i,
    input  logic                 wb_valid_i,
    input  logic [WB_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]    wb_data_i,
    input  logic                 rec_ready_i,
    output logic                 rec_valid_o,
    output logic [REC_W-1:0]     rec_data_o,
    output logic [LVL_W-1:0]     fill_level_o,
    output logic [CC_W-1:0]      cycle_cnt_o,
    output logic [CC_W-1:0]      retire_cnt_o,
    output logic [CC_W-1:0]      stall_cnt_o,
    output logic [CC_W-1:0]      halt_cnt_o,
    output logic [PC_W-1:0]      halt_pc_o,
    output logic [CC_W-1:0]      drop_cnt_o,
    output logic                 overflow_o,
    output logic                 halted_o
);

    // The drain counter runs 0..NUM_STAGES-2, giving NUM_STAGES-1 cycles in DRAIN.
    localparam int unsigned      DRAIN_W    = (NUM_STAGES > 2) ? $clog2(NUM_STAGES - 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(NUM_STAGES - 2);
    localparam logic [CC_W-1:0]  CNT_ONE    = CC_W'(1);

    function automatic logic [CC_W-1:0] sat_inc(input logic [CC_W-1:0] v, input logic hit);
        if (hit && (v != {CC_W{1'b1}})) return v + CNT_ONE;
        else                            return v;
    endfunction

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CC_W-1:0]    cycle_q, cycle_d, retire_q, retire_d, stall_q, stall_d;
    logic [CC_W-1:0]    halt_cnt_q, halt_cnt_d, drop_q, drop_d;
    logic [PC_W-1:0]    halt_pc_q, halt_pc_d;
    logic               overflow_q, overflow_d, halted_q, halted_d;
    logic               active_s, halt_fetch_s, push_s, pop_s, full_s, drop_s;

    assign active_s     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign halt_fetch_s = (state_q == ST_RUN) && fetch_valid_i && (inst_f_i == HALT_INST);
    assign push_s       = active_s && wb_valid_i && !clr_i;
    assign pop_s        = rec_valid_o && rec_ready_i;
    assign drop_s       = push_s && full_s && !pop_s;

    pipe_trace_monitor_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (push_s),
        .data_i  ({cycle_q, wb_addr_i, wb_data_i}),
        .pop_i   (rec_ready_i),
        .valid_o (rec_valid_o),
        .data_o  (rec_data_o),
        .full_o  (full_s),
        .level_o (fill_level_o)
    );

    // Control state and counter next-state; clear takes priority over everything.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        stall_d    = stall_q;
        halt_cnt_d = halt_cnt_q;
        halt_pc_d  = halt_pc_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        if (clr_i) begin
            state_d    = ST_IDLE;
            drain_d    = '0;
            cycle_d    = '0;
            retire_d   = '0;
            stall_d    = '0;
            halt_cnt_d = '0;
            halt_pc_d  = '0;
            drop_d     = '0;
            overflow_d = 1'b0;
            halted_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_i) state_d = ST_RUN;
                    else      state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (halt_fetch_s && STOP_ON_HALT) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else if (!en_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                    else                       drain_d = drain_q + DRAIN_W'(1);
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
            cycle_d    = sat_inc(cycle_q, active_s);
            stall_d    = sat_inc(stall_q, (state_q == ST_RUN) && stall_f_i);
            retire_d   = sat_inc(retire_q, push_s);
            drop_d     = sat_inc(drop_q, drop_s);
            halt_cnt_d = sat_inc(halt_cnt_q, halt_fetch_s);
            if (halt_fetch_s && (halt_cnt_q == '0)) halt_pc_d = pc_f_i;
            else                                    halt_pc_d = halt_pc_q;
            overflow_d = overflow_q || drop_s;
            halted_d   = (state_d == ST_DONE);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            halt_cnt_q <= '0;
            halt_pc_q  <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            stall_q    <= stall_d;
            halt_cnt_q <= halt_cnt_d;
            halt_pc_q  <= halt_pc_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;
    assign stall_cnt_o  = stall_q;
    assign halt_cnt_o   = halt_cnt_q;
    assign halt_pc_o    = halt_pc_q;
    assign drop_cnt_o   = drop_q;
    assign overflow_o   = overflow_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Self-checking bench for pipe_trace_monitor: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pipe_trace_monitor;

    localparam int          DEPTH      = 16;
    localparam int          NUM_STAGES = 5;
    localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
    localparam longint      SAT        = 64'h0000_0000_FFFF_FFFF;
    localparam int          M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    logic        fetch_valid = 1'b0, stall_f = 1'b0, wb_valid = 1'b0, rec_ready = 1'b0;
    logic [31:0] inst_f = '0, pc_f = '0, wb_data = '0;
    logic [4:0]  wb_addr = '0;

    logic        rec_valid, overflow, halted, nh_rec_valid, nh_overflow, nh_halted;
    logic [68:0] rec_data, nh_rec_data;
    logic [4:0]  fill, nh_fill;
    logic [31:0] cycle_cnt, retire_cnt, stall_cnt, halt_cnt, halt_pc, drop_cnt;
    logic [31:0] nh_cycle_cnt, nh_retire_cnt, nh_stall_cnt, nh_halt_cnt, nh_halt_pc, nh_drop_cnt;
    logic [268:0] dut_all, nh_all;

    assign dut_all = {rec_valid, rec_data, fill, cycle_cnt, retire_cnt, stall_cnt, halt_cnt,
                      halt_pc, drop_cnt, overflow, halted};
    assign nh_all  = {nh_rec_valid, nh_rec_data, nh_fill, nh_cycle_cnt, nh_retire_cnt, nh_stall_cnt,
                      nh_halt_cnt, nh_halt_pc, nh_drop_cnt, nh_overflow, nh_halted};

    pipe_trace_monitor #(.STOP_ON_HALT(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .inst_f_i(inst_f), .pc_f_i(pc_f),
        .fetch_valid_i(fetch_valid), .stall_f_i(stall_f), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .rec_ready_i(rec_ready), .rec_valid_o(rec_valid), .rec_data_o(rec_data),
        .fill_level_o(fill), .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt), .stall_cnt_o(stall_cnt),
        .halt_cnt_o(halt_cnt), .halt_pc_o(halt_pc), .drop_cnt_o(drop_cnt), .overflow_o(overflow),
        .halted_o(halted));

    pipe_trace_monitor #(.STOP_ON_HALT(1'b0)) dut_nh (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .inst_f_i(inst_f), .pc_f_i(pc_f),
        .fetch_valid_i(fetch_valid), .stall_f_i(stall_f), .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
        .wb_data_i(wb_data), .rec_ready_i(rec_ready), .rec_valid_o(nh_rec_valid), .rec_data_o(nh_rec_data),
        .fill_level_o(nh_fill), .cycle_cnt_o(nh_cycle_cnt), .retire_cnt_o(nh_retire_cnt),
        .stall_cnt_o(nh_stall_cnt), .halt_cnt_o(nh_halt_cnt), .halt_pc_o(nh_halt_pc),
        .drop_cnt_o(nh_drop_cnt), .overflow_o(nh_overflow), .halted_o(nh_halted));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the STOP_ON_HALT=1 instance.
    int          m_mode, m_drain_left;
    longint      m_cycle, m_retire, m_stall, m_halt, m_drop;
    logic [31:0] m_halt_pc;
    bit          m_ovf;
    logic [68:0] m_q[$];

    task automatic model_clear();
        m_mode = M_IDLE; m_drain_left = 0;
        m_cycle = 0; m_retire = 0; m_stall = 0; m_halt = 0; m_drop = 0;
        m_halt_pc = '0; m_ovf = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step(input logic s_en, input logic s_clr, input logic [31:0] s_inst,
                              input logic [31:0] s_pc, input logic s_fv, input logic s_stall,
                              input logic s_wbv, input logic [4:0] s_wba, input logic [31:0] s_wbd,
                              input logic s_rdy);
        bit active, halt;
        if (s_clr) begin
            model_clear();
            return;
        end
        active = (m_mode == M_RUN) || (m_mode == M_DRAIN);
        halt   = (m_mode == M_RUN) && s_fv && (s_inst == HALT);
        if (m_q.size() > 0 && s_rdy) void'(m_q.pop_front());
        if (active && s_wbv) begin
            if (m_retire < SAT) m_retire++;
            if (m_q.size() < DEPTH) m_q.push_back({m_cycle[31:0], s_wba, s_wbd});
            else begin
                if (m_drop < SAT) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (active && m_cycle < SAT) m_cycle++;
        if (m_mode == M_RUN && s_stall && m_stall < SAT) m_stall++;
        if (halt) begin
            if (m_halt == 0) m_halt_pc = s_pc;
            if (m_halt < SAT) m_halt++;
        end
        case (m_mode)
            M_IDLE:  if (s_en) m_mode = M_RUN;
            M_RUN:   if (halt) begin m_mode = M_DRAIN; m_drain_left = NUM_STAGES - 1; end
                     else if (!s_en) m_mode = M_IDLE;
            M_DRAIN: begin
                m_drain_left--;
                if (m_drain_left == 0) m_mode = M_DONE;
            end
            default: m_mode = M_DONE;
        endcase
    endtask

    // One clock: inputs held across the edge feed the model, outputs settle by +1.
    task automatic tick();
        logic s_en, s_clr, s_fv, s_stall, s_wbv, s_rdy;
        logic [31:0] s_inst, s_pc, s_wbd;
        logic [4:0]  s_wba;
        s_en = en; s_clr = clr; s_fv = fetch_valid; s_stall = stall_f; s_wbv = wb_valid;
        s_rdy = rec_ready; s_inst = inst_f; s_pc = pc_f; s_wbd = wb_data; s_wba = wb_addr;
        @(posedge clk);
        model_step(s_en, s_clr, s_inst, s_pc, s_fv, s_stall, s_wbv, s_wba, s_wbd, s_rdy);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (dut_all !== '0) $display("FAIL por_zero: got %h expected 0", dut_all); else n_pass++;
        #1 rst_n = 1'b1;
        en = 1'b1; tick();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_addr = 5'($urandom); wb_data = $urandom; tick();
        end
        wb_valid = 1'b0;
        n_checks++;
        if (fill !== 5'd3) $display("FAIL pre_reset_fill: got %0d expected 3", fill); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (dut_all !== '0) $display("FAIL reset_zero: got %h expected 0", dut_all); else n_pass++;
        n_checks++;
        if (nh_all !== '0) $display("FAIL reset_zero_nh: got %h expected 0", nh_all); else n_pass++;
        en = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic_trace();
        do_clear();
        en = 1'b1; rec_ready = 1'b0; tick();
        tick(); tick();
        n_checks++;
        if (cycle_cnt !== 32'd2) $display("FAIL basic_cycle: got %0d expected 2", cycle_cnt); else n_pass++;
        wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'd5; tick();
        wb_addr = 5'd9; wb_data = 32'd7; tick();
        wb_valid = 1'b0;
        n_checks++;
        if (rec_data !== {32'd2, 5'd8, 32'd5} || rec_valid !== 1'b1)
            $display("FAIL basic_rec0: got %h/%b expected %h/1", rec_data, rec_valid, {32'd2, 5'd8, 32'd5});
        else n_pass++;
        n_checks++;
        if (retire_cnt !== 32'd2) $display("FAIL basic_retire: got %0d expected 2", retire_cnt); else n_pass++;
        rec_ready = 1'b1; tick();
        n_checks++;
        if (rec_data !== {32'd3, 5'd9, 32'd7})
            $display("FAIL basic_rec1: got %h expected %h", rec_data, {32'd3, 5'd9, 32'd7});
        else n_pass++;
        tick();
        n_checks++;
        if (rec_valid !== 1'b0 || fill !== 5'd0)
            $display("FAIL basic_empty: got valid %b fill %0d expected 0 0", rec_valid, fill);
        else n_pass++;
    endtask

    task automatic test_halt_drain();
        longint retire_before;
        do_clear();
        en = 1'b1; rec_ready = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
            inst_f = $urandom & 32'h7FFF_FFFF; fetch_valid = 1'($urandom); stall_f = 1'($urandom);
            tick();
        end
        wb_valid = 1'b0; stall_f = 1'b0;
        inst_f = HALT; pc_f = 32'h40; fetch_valid = 1'b1; tick();
        retire_before = m_retire;
        n_checks++;
        if (halt_pc !== 32'h40 || halt_cnt !== 32'd1)
            $display("FAIL halt_capture: got pc %h cnt %0d expected 40 1", halt_pc, halt_cnt);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); pc_f = 32'h44 + 32'(4 * i);
            wb_valid = 1'b1; wb_addr = 5'($urandom); wb_data = $urandom;
            tick();
            n_checks++;
            if (halted !== (i == 3)) $display("FAIL drain_halted_%0d: got %b expected %b", i, halted, i == 3);
            else n_pass++;
        end
        n_checks++;
        if (retire_cnt !== 32'(retire_before + 4) || halt_cnt !== 32'd1)
            $display("FAIL drain_retire: got %0d/%0d expected %0d/1", retire_cnt, halt_cnt, retire_before + 4);
        else n_pass++;
        tick();
        n_checks++;
        if (retire_cnt !== 32'(retire_before + 4))
            $display("FAIL done_no_push: got %0d expected %0d", retire_cnt, retire_before + 4);
        else n_pass++;
        wb_valid = 1'b0; fetch_valid = 1'b0; rec_ready = 1'b1;
        for (int k = 0; k < DEPTH + 2 && m_q.size() > 0; k++) begin
            n_checks++;
            if (rec_valid !== 1'b1 || rec_data !== m_q[0])
                $display("FAIL drain_rec_%0d: got %b/%h expected 1/%h", k, rec_valid, rec_data, m_q[0]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (rec_valid !== 1'b0 || halted !== 1'b1)
            $display("FAIL drain_final: got valid %b halted %b expected 0 1", rec_valid, halted);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [68:0] exp_rec[DEPTH];
        do_clear();
        en = 1'b1; rec_ready = 1'b0; tick();
        for (int i = 0; i < 20; i++) begin
            wb_valid = 1'b1; wb_addr = 5'($urandom); wb_data = $urandom;
            if (i < DEPTH) exp_rec[i] = {32'(i), wb_addr, wb_data};
            tick();
        end
        wb_valid = 1'b0;
        n_checks++;
        if (fill !== 5'd16 || drop_cnt !== 32'd4 || overflow !== 1'b1 || retire_cnt !== 32'd20)
            $display("FAIL ovf_state: got fill %0d drop %0d ovf %b retire %0d expected 16 4 1 20",
                     fill, drop_cnt, overflow, retire_cnt);
        else n_pass++;
        en = 1'b0; rec_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (rec_valid !== 1'b1 || rec_data !== exp_rec[i])
                $display("FAIL ovf_pop_%0d: got %b/%h expected 1/%h", i, rec_valid, rec_data, exp_rec[i]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (rec_valid !== 1'b0 || fill !== 5'd0 || overflow !== 1'b1)
            $display("FAIL ovf_drained: got valid %b fill %0d ovf %b expected 0 0 1", rec_valid, fill, overflow);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        do_clear();
        en = 1'b1; rec_ready = 1'b0; tick();
        for (int i = 0; i < DEPTH; i++) begin
            wb_valid = 1'b1; wb_addr = 5'(i); wb_data = $urandom; tick();
        end
        rec_ready = 1'b1; wb_addr = 5'd31; wb_data = $urandom; tick();
        n_checks++;
        if (fill !== 5'd16 || drop_cnt !== 32'd0 || retire_cnt !== 32'd17)
            $display("FAIL full_pushpop: got fill %0d drop %0d retire %0d expected 16 0 17", fill, drop_cnt, retire_cnt);
        else n_pass++;
        n_checks++;
        if (rec_data !== m_q[0] || rec_data[68:37] !== 32'd1)
            $display("FAIL full_head: got %h expected %h", rec_data, m_q[0]);
        else n_pass++;
        rec_ready = 1'b0; tick();
        n_checks++;
        if (drop_cnt !== 32'd1 || overflow !== 1'b1)
            $display("FAIL full_drop: got %0d/%b expected 1/1", drop_cnt, overflow);
        else n_pass++;
        wb_valid = 1'b0;
    endtask

    task automatic test_no_stop_halt();
        logic [31:0] pc1;
        en = 1'b0; do_clear();
        pc1 = $urandom & 32'hFFFF_FFFC;
        en = 1'b1; tick();
        inst_f = HALT; fetch_valid = 1'b1; pc_f = pc1; tick();
        fetch_valid = 1'b0; inst_f = '0; tick();
        inst_f = HALT; fetch_valid = 1'b1; pc_f = pc1 + 32'd8; tick();
        fetch_valid = 1'b0; inst_f = '0; tick(); tick();
        n_checks++;
        if (nh_halt_cnt !== 32'd2 || nh_halt_pc !== pc1 || nh_halted !== 1'b0)
            $display("FAIL nh_halt: got cnt %0d pc %h halted %b expected 2 %h 0", nh_halt_cnt, nh_halt_pc, nh_halted, pc1);
        else n_pass++;
        n_checks++;
        if (nh_cycle_cnt !== 32'd5) $display("FAIL nh_still_run: got %0d expected 5", nh_cycle_cnt); else n_pass++;
        n_checks++;
        if (halt_cnt !== 32'd1 || halted !== 1'b1)
            $display("FAIL stop_halt_done: got cnt %0d halted %b expected 1 1", halt_cnt, halted);
        else n_pass++;
        do_clear();
        en = 1'b0; tick();
        n_checks++;
        if (nh_all !== '0) $display("FAIL nh_clr_zero: got %h expected 0", nh_all); else n_pass++;
        n_checks++;
        if (dut_all !== '0) $display("FAIL clr_zero: got %h expected 0", dut_all); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            en          = ($urandom % 8) != 0;
            clr         = ($urandom % 80) == 0;
            fetch_valid = 1'($urandom);
            inst_f      = (($urandom % 24) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
            pc_f        = $urandom & 32'hFFFF_FFFC;
            stall_f     = 1'($urandom);
            wb_valid    = 1'($urandom);
            wb_addr     = 5'($urandom);
            wb_data     = $urandom;
            rec_ready   = ((i / 100) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            tick();
            n_checks++;
            if (fill !== 5'(m_q.size()) || rec_valid !== (m_q.size() != 0))
                $display("FAIL rnd_fill_%0d: got %0d/%b expected %0d", i, fill, rec_valid, m_q.size());
            else n_pass++;
            if (m_q.size() != 0) begin
                n_checks++;
                if (rec_data !== m_q[0]) $display("FAIL rnd_head_%0d: got %h expected %h", i, rec_data, m_q[0]);
                else n_pass++;
            end
            n_checks++;
            if ({cycle_cnt, retire_cnt, stall_cnt, drop_cnt} !==
                {m_cycle[31:0], m_retire[31:0], m_stall[31:0], m_drop[31:0]})
                $display("FAIL rnd_cnt_%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", i, cycle_cnt,
                         retire_cnt, stall_cnt, drop_cnt, m_cycle, m_retire, m_stall, m_drop);
            else n_pass++;
            n_checks++;
            if ({halt_cnt, halt_pc, overflow, halted} !== {m_halt[31:0], m_halt_pc, m_ovf, m_mode == M_DONE})
                $display("FAIL rnd_halt_%0d: got %0d %h %b %b expected %0d %h %b %b", i, halt_cnt, halt_pc,
                         overflow, halted, m_halt, m_halt_pc, m_ovf, m_mode == M_DONE);
            else n_pass++;
        end
        clr = 1'b0;
    endtask

    initial begin
        model_clear();
        #1;
        test_reset();
        test_basic_trace();
        test_halt_drain();
        test_overflow();
        test_full_push_pop();
        test_no_stop_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
